// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
//   Two-port arbiter in front of a single-ported 96k x 16 framebuffer.
//   The display (scanout) port normally has priority. The CPU wins a
//   contested cycle once it has lost STARVE_LIMIT contested cycles in a row.
//   One access is granted per cycle. The address, data and write enable are
//   registered one cycle after the grant. Read data comes back two cycles
//   after the grant and is routed to its owner by a tag pipeline.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_ack, cpu_rvalid, cpu_rdata, cpu_err
//   disp_req/addr         -> disp_ack, disp_rvalid, disp_rdata
//   fb_addr/fb_din/fb_we  : registered framebuffer request
//   fb_dout               : framebuffer read data, one cycle after fb_addr
module framebuffer_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_LIMIT   = 98304
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        disp_req,
  input  logic [16:0] disp_addr,
  output logic        disp_ack,
  output logic        disp_rvalid,
  output logic [15:0] disp_rdata,
  output logic [16:0] fb_addr,
  output logic [15:0] fb_din,
  output logic        fb_we,
  input  logic [15:0] fb_dout
);

  localparam int          STAGES = 2;
  localparam logic [3:0]  LIMIT  = 4'(STARVE_LIMIT);
  localparam logic [17:0] ALIM   = 18'(ADDR_LIMIT);

  typedef enum logic [1:0] {G_IDLE, G_DISP, G_CPU} gnt_e;

  // rd: a read is in flight; cpu: owner is the CPU; oor: address out of range
  typedef struct packed {
    logic rd;
    logic cpu;
    logic oor;
  } tag_t;

  logic                 cpu_gnt, disp_gnt;
  logic [16:0]          g_addr;
  logic                 g_we, g_oor;
  logic [3:0]           starve_cnt_q, starve_cnt_d;
  gnt_e                 gnt_q, gnt_d;
  logic [16:0]          fb_addr_q, fb_addr_d;
  logic [15:0]          fb_din_q, fb_din_d;
  logic                 fb_we_q, fb_we_d;
  tag_t [STAGES:1]      tag_pipe_q, tag_pipe_d;
  logic [15:0]          cpu_rdata_q, cpu_rdata_d;
  logic [15:0]          disp_rdata_q, disp_rdata_d;
  logic [15:0]          rd_word;
  logic                 cpu_rv, disp_rv;

  // Grant: display first, unless the CPU has been starved long enough.
  always_comb begin
    disp_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    if (!reset) begin
      disp_gnt = disp_req && !(cpu_req && (starve_cnt_q == LIMIT));
      cpu_gnt  = cpu_req && !disp_gnt;
    end
  end

  always_comb begin
    g_addr = cpu_gnt ? cpu_addr : disp_addr;
    g_we   = cpu_gnt && cpu_we;
    g_oor  = ({1'b0, g_addr} >= ALIM);
  end

  always_comb begin
    starve_cnt_d = (cpu_req && disp_gnt) ? starve_cnt_q + 4'd1 : 4'd0;
    gnt_d        = cpu_gnt ? G_CPU : (disp_gnt ? G_DISP : G_IDLE);

    // Framebuffer request stage; out-of-range grants leave the bus idle.
    fb_addr_d = fb_addr_q;
    fb_din_d  = fb_din_q;
    fb_we_d   = 1'b0;
    if ((cpu_gnt || disp_gnt) && !g_oor) begin
      fb_addr_d = g_addr;
      fb_we_d   = g_we;
      if (g_we) fb_din_d = cpu_wdata;
    end

    // The oor bit of stage 1 is set for any grant so it also drives cpu_err.
    tag_pipe_d[1] = '0;
    if (cpu_gnt || disp_gnt) begin
      tag_pipe_d[1].rd  = !g_we;
      tag_pipe_d[1].cpu = cpu_gnt;
      tag_pipe_d[1].oor = g_oor;
    end
    for (int s = 2; s <= STAGES; s++) tag_pipe_d[s] = tag_pipe_q[s-1];
  end

  // fb_dout lines up with the last tag stage; rdata is taken straight from
  // it in that cycle and held in a register otherwise.
  always_comb begin
    rd_word      = tag_pipe_q[STAGES].oor ? 16'h0 : fb_dout;
    cpu_rv       = !reset && tag_pipe_q[STAGES].rd && tag_pipe_q[STAGES].cpu;
    disp_rv      = !reset && tag_pipe_q[STAGES].rd && !tag_pipe_q[STAGES].cpu;
    cpu_rdata_d  = cpu_rv  ? rd_word : cpu_rdata_q;
    disp_rdata_d = disp_rv ? rd_word : disp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      gnt_q        <= G_IDLE;
      fb_addr_q    <= '0;
      fb_din_q     <= '0;
      fb_we_q      <= 1'b0;
      tag_pipe_q   <= '0;
      cpu_rdata_q  <= '0;
      disp_rdata_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      gnt_q        <= gnt_d;
      fb_addr_q    <= fb_addr_d;
      fb_din_q     <= fb_din_d;
      fb_we_q      <= fb_we_d;
      tag_pipe_q   <= tag_pipe_d;
      cpu_rdata_q  <= cpu_rdata_d;
      disp_rdata_q <= disp_rdata_d;
    end
  end

  // Registered state only lands at the next edge, so outputs are also
  // forced low combinationally for the whole time reset is high.
  assign cpu_ack     = cpu_gnt;
  assign disp_ack    = disp_gnt;
  assign cpu_err     = !reset && (gnt_q == G_CPU) && tag_pipe_q[1].oor;
  assign cpu_rvalid  = cpu_rv;
  assign disp_rvalid = disp_rv;
  assign cpu_rdata   = reset ? 16'h0 : cpu_rdata_d;
  assign disp_rdata  = reset ? 16'h0 : disp_rdata_d;
  assign fb_addr     = reset ? 17'h0 : fb_addr_q;
  assign fb_din      = reset ? 16'h0 : fb_din_q;
  assign fb_we       = !reset && fb_we_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Scoreboard bench for framebuffer_arbiter: a driver issues CPU/display
// transactions and predicts grants and responses from a queue-based model;
// a forked monitor checks every cycle against the expectation queues.
module tb_framebuffer_arbiter;
  localparam int SL = 4;
  localparam int AL = 98304;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack, cpu_rvalid, cpu_err;
  logic [15:0] cpu_rdata;
  logic        disp_req = 1'b0;
  logic [16:0] disp_addr = '0;
  logic        disp_ack, disp_rvalid;
  logic [15:0] disp_rdata;
  logic [16:0] fb_addr;
  logic [15:0] fb_din;
  logic        fb_we;
  logic [15:0] fb_dout = '0;

  always #5 clk = ~clk;

  framebuffer_arbiter #(.STARVE_LIMIT(SL), .ADDR_LIMIT(AL)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .fb_addr(fb_addr), .fb_din(fb_din), .fb_we(fb_we), .fb_dout(fb_dout)
  );

  typedef struct { logic we; logic [16:0] addr; logic [15:0] data; } txn_t;
  typedef struct { int due; logic we; logic [16:0] addr; logic [15:0] data; } exp_t;

  txn_t cpu_txn[$], disp_txn[$];
  exp_t fb_q[$], crd_q[$], drd_q[$];
  int   err_q[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   cpu_rate = 100, disp_rate = 100;
  bit   cpu_hold = 0, disp_hold = 0;
  int   lost = 0, dut_wait = 0;
  logic [15:0] ref_mem [int];
  logic [15:0] fb_mem [int];
  logic [15:0] last_crd = '0, last_drd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(logic [16:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {15'd0, a[16]};
  endfunction

  // Framebuffer: registered read, one cycle latency.
  always @(posedge clk) begin
    fb_dout <= fb_mem.exists(int'(fb_addr)) ? fb_mem[int'(fb_addr)] : pat(fb_addr);
    if (fb_we) fb_mem[int'(fb_addr)] = fb_din;
  end

  function automatic logic [15:0] ref_rd(logic [16:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endfunction

  task automatic monitor();
    exp_t e;
    bit   hit;
    logic exp_we;
    forever begin
      @(negedge clk);
      if (reset) begin
        fb_q.delete(); crd_q.delete(); drd_q.delete(); err_q.delete();
        last_crd = '0; last_drd = '0;
      end else begin
        hit    = (fb_q.size() > 0) && (fb_q[0].due == cyc);
        exp_we = 1'b0;
        if (hit) exp_we = fb_q[0].we;
        chk("fb_we", 64'(fb_we), 64'(exp_we));
        if (hit) begin
          e = fb_q.pop_front();
          chk("fb_addr", 64'(fb_addr), 64'(e.addr));
          if (e.we) chk("fb_din", 64'(fb_din), 64'(e.data));
        end
        hit = (err_q.size() > 0) && (err_q[0] == cyc);
        chk("cpu_err", 64'(cpu_err), 64'(hit));
        if (hit) void'(err_q.pop_front());
        hit = (crd_q.size() > 0) && (crd_q[0].due == cyc);
        chk("cpu_rvalid", 64'(cpu_rvalid), 64'(hit));
        if (hit) begin
          e = crd_q.pop_front();
          chk("cpu_rdata", 64'(cpu_rdata), 64'(e.data));
          last_crd = e.data;
        end else chk("cpu_rdata_hold", 64'(cpu_rdata), 64'(last_crd));
        hit = (drd_q.size() > 0) && (drd_q[0].due == cyc);
        chk("disp_rvalid", 64'(disp_rvalid), 64'(hit));
        if (hit) begin
          e = drd_q.pop_front();
          chk("disp_rdata", 64'(disp_rdata), 64'(e.data));
          last_drd = e.data;
        end else chk("disp_rdata_hold", 64'(disp_rdata), 64'(last_drd));
      end
    end
  endtask

  // One cycle: called just after a rising edge, returns just after the next.
  task automatic step();
    bit   eg_d, eg_c, oor;
    txn_t t;
    if (!cpu_hold && cpu_txn.size() > 0 && $urandom_range(99) < cpu_rate) cpu_hold = 1;
    if (!disp_hold && disp_txn.size() > 0 && $urandom_range(99) < disp_rate) disp_hold = 1;
    cpu_req  = cpu_hold;
    disp_req = disp_hold;
    if (cpu_hold) begin
      cpu_we = cpu_txn[0].we; cpu_addr = cpu_txn[0].addr; cpu_wdata = cpu_txn[0].data;
    end else begin
      cpu_we = 1'($urandom); cpu_addr = 17'($urandom); cpu_wdata = 16'($urandom);
    end
    disp_addr = disp_hold ? disp_txn[0].addr : 17'($urandom);
    @(negedge clk);
    // Display wins a contested cycle unless the CPU already lost SL in a row.
    eg_d = disp_hold && !(cpu_hold && lost == SL);
    eg_c = cpu_hold && !eg_d;
    chk("disp_ack", 64'(disp_ack), 64'(eg_d));
    chk("cpu_ack", 64'(cpu_ack), 64'(eg_c));
    if (cpu_req) begin
      if (cpu_ack) begin
        chk("cpu_wait_bound", 64'(dut_wait <= SL), 64'd1);
        dut_wait = 0;
      end else dut_wait++;
    end
    if (eg_c) begin
      t = cpu_txn.pop_front(); cpu_hold = 0;
      oor = int'(t.addr) >= AL;
      if (oor) err_q.push_back(cyc + 1);
      else begin
        fb_q.push_back('{cyc + 1, t.we, t.addr, t.data});
        if (t.we) ref_mem[int'(t.addr)] = t.data;
      end
      if (!t.we) crd_q.push_back('{cyc + 2, 1'b0, t.addr, oor ? 16'h0 : ref_rd(t.addr)});
    end
    if (eg_d) begin
      t = disp_txn.pop_front(); disp_hold = 0;
      oor = int'(t.addr) >= AL;
      if (!oor) fb_q.push_back('{cyc + 1, 1'b0, t.addr, 16'h0});
      drd_q.push_back('{cyc + 2, 1'b0, t.addr, oor ? 16'h0 : ref_rd(t.addr)});
    end
    lost = (cpu_hold && eg_d) ? lost + 1 : 0;
    @(posedge clk); #1;
  endtask

  task automatic run(int budget);
    int n = 0;
    while ((cpu_txn.size() > 0 || disp_txn.size() > 0) && n < budget) begin
      step(); n++;
    end
    chk("run_done", 64'(cpu_txn.size() + disp_txn.size()), 64'd0);
    repeat (4) step();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    cpu_req = 1'b1; disp_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 17'h10; cpu_wdata = 16'hFFFF; disp_addr = 17'h20;
    cpu_hold = 0; disp_hold = 0; lost = 0; dut_wait = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_acks", 64'({cpu_ack, disp_ack}), 64'd0);
      chk("rst_pulses", 64'({cpu_rvalid, disp_rvalid, cpu_err, fb_we}), 64'd0);
      chk("rst_fb", 64'({fb_addr, fb_din}), 64'd0);
      chk("rst_rdata", 64'({cpu_rdata, disp_rdata}), 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0; cpu_req = 1'b0; disp_req = 1'b0;
  endtask

  initial begin
    fork monitor(); join_none
    do_reset(3);

    // CPU write then read back of 0x00010.
    cpu_rate = 100; disp_rate = 100;
    cpu_txn.push_back('{1'b1, 17'h00010, 16'hBEEF});
    cpu_txn.push_back('{1'b0, 17'h00010, 16'h0});
    run(20);

    // Continuous contention: D,D,D,D,C pattern.
    for (int i = 0; i < 12; i++) cpu_txn.push_back('{1'b0, 17'(32'h200 + i), 16'h0});
    for (int i = 0; i < 60; i++) disp_txn.push_back('{1'b0, 17'(32'h400 + i), 16'h0});
    run(200);

    // Back-to-back display reads 0x100..0x107.
    for (int i = 0; i < 8; i++) disp_txn.push_back('{1'b0, 17'(32'h100 + i), 16'h0});
    run(20);

    // Out of range write and read.
    cpu_txn.push_back('{1'b1, 17'h18000, 16'h1234});
    cpu_txn.push_back('{1'b0, 17'h1FFFF, 16'h0});
    cpu_txn.push_back('{1'b0, 17'h17FFF, 16'h0});
    run(20);

    // Reset one cycle after a display read ack: the read must vanish.
    disp_txn.push_back('{1'b0, 17'h00100, 16'h0});
    step();
    do_reset(2);
    repeat (6) step();

    // CPU read in N, display read in N+1.
    cpu_txn.push_back('{1'b0, 17'h00010, 16'h0});
    step();
    disp_txn.push_back('{1'b0, 17'h00100, 16'h0});
    run(20);

    // Randomized traffic, two rounds at different rates.
    for (int r = 0; r < 2; r++) begin
      cpu_rate  = (r == 0) ? 60 : 100;
      disp_rate = (r == 0) ? 40 : 90;
      for (int i = 0; i < 80; i++) begin
        logic [16:0] a;
        a = ($urandom_range(7) == 0) ? 17'($urandom_range(131071, AL))
                                     : 17'($urandom_range(255));
        cpu_txn.push_back('{1'($urandom), a, 16'($urandom)});
        a = ($urandom_range(9) == 0) ? 17'($urandom_range(131071, AL))
                                     : 17'($urandom_range(255));
        disp_txn.push_back('{1'b0, a, 16'h0});
      end
      run(2000);
    end

    chk("fb_q_empty", 64'(fb_q.size() + crd_q.size() + drd_q.size() + err_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_arbiter.md
FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive contested display grants before the CPU wins; legal range 1-15.
REQ-002 SHALL have parameter ADDR_LIMIT, default 98304: first illegal word address (96k x 16-bit framebuffer).
REQ-003 SHALL have port clk, input, 1: single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cpu_req, input, 1: CPU access request; held until cpu_ack.
REQ-006 SHALL have port cpu_we, input, 1: 1 = write, 0 = read; sampled with cpu_req.
REQ-007 SHALL have port cpu_addr, input, 17: CPU word address.
REQ-008 SHALL have port cpu_wdata, input, 16: CPU write data.
REQ-009 SHALL have port cpu_ack, output, 1: one-cycle pulse; CPU request accepted this cycle.
REQ-010 SHALL have port cpu_rvalid, output, 1: one-cycle pulse; cpu_rdata is valid.
REQ-011 SHALL have port cpu_rdata, output, 16: CPU read data.
REQ-012 SHALL have port cpu_err, output, 1: one-cycle pulse; accepted CPU address was out of range.
REQ-013 SHALL have port disp_req, input, 1: scanout read request; held until disp_ack.
REQ-014 SHALL have port disp_addr, input, 17: scanout word address.
REQ-015 SHALL have port disp_ack, output, 1: one-cycle pulse; display request accepted.
REQ-016 SHALL have port disp_rvalid, output, 1: one-cycle pulse; disp_rdata is valid.
REQ-017 SHALL have port disp_rdata, output, 16: display read data.
REQ-018 SHALL have port fb_addr, output, 17: registered framebuffer address.
REQ-019 SHALL have port fb_din, output, 16: registered framebuffer write data.
REQ-020 SHALL have port fb_we, output, 1: registered framebuffer write enable.
REQ-021 SHALL have port fb_dout, input, 16: framebuffer read data, valid one cycle after fb_addr is presented.

Function
REQ-022 SHALL grant at most one request per cycle; ack is combinational from registered state and req; throughput is one access per cycle, back-to-back.
REQ-023 SHALL, when exactly one requester is active, grant it.
REQ-024 SHALL, when both are active, grant display unless starve_cnt == STARVE_LIMIT, in which case CPU wins.
REQ-025 SHALL increment the 4-bit starve_cnt each cycle cpu_req is high and display is granted; clear it when CPU is granted or cpu_req is low.
REQ-026 SHALL maintain a grant-state register: IDLE (no grant), DISP (display granted), CPU (CPU granted); it is updated each cycle from that cycle's grant.
REQ-027 SHALL, for an in-range grant in cycle N, drive fb_addr = address, fb_din = wdata (CPU write) and fb_we = cpu_we (0 for display) in cycle N+1.
REQ-028 SHALL drive fb_we = 0 in any cycle not following a granted in-range CPU write; fb_addr and fb_din hold their last value.
REQ-029 SHALL, for a read granted in cycle N, pulse the owner's rvalid in cycle N+2, with rdata = fb_dout.
REQ-030 SHALL route read data by a 2-stage owner-tag pipeline; the non-owner's rvalid stays 0 and its rdata holds its previous value.
REQ-031 SHALL treat addr >= ADDR_LIMIT as out of range and still ack it.
REQ-032 SHALL, for an out-of-range access: keep fb_we = 0; pulse cpu_err in N+1 (CPU only); return rvalid in N+2 with rdata = 0 for reads.
REQ-033 SHALL produce no write acknowledgement other than cpu_ack.

Reset
REQ-034 SHALL, while reset is high, force outputs to: all acks, rvalids, cpu_err and fb_we = 0; fb_addr, fb_din, cpu_rdata and disp_rdata = 0; grant state IDLE; starve_cnt = 0; tag pipeline empty.
REQ-035 SHALL issue no ack while reset is high.
REQ-036 SHALL discard reads in flight at reset; no rvalid appears after reset deasserts for a request accepted before reset.

Verification
REQ-037 SHALL cover: CPU write addr 0x00010, data 0xBEEF, ack in cycle N -> fb_we=1, fb_addr=0x00010, fb_din=0xBEEF in N+1; a later read of 0x00010 -> cpu_rdata=0xBEEF at ack+2.
REQ-038 SHALL cover: both requesting continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,C repeating; CPU never waits more than 5 cycles.
REQ-039 SHALL cover: display reads 0x00100..0x00107 back-to-back -> 8 consecutive disp_rvalid pulses, in order, each at ack+2.
REQ-040 SHALL cover: CPU write to 0x18000 (98304) -> cpu_ack, cpu_err in N+1, fb_we stays 0; a read of 0x1FFFF -> rdata 0, cpu_err.
REQ-041 SHALL cover: reset asserted one cycle after a display read ack -> no disp_rvalid afterwards, all outputs 0 during reset.
REQ-042 SHALL cover: CPU read acked in N, display read acked in N+1 -> cpu_rvalid in N+2, disp_rvalid in N+3, with no cross-delivery of data.
